// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline register stage with optional two-entry skid buffer
module pipe_stage_skid #(
  parameter int DATA_W  = 32,
  parameter int NCH     = 2,
  parameter int ADDR_W  = 5,
  parameter int CTRL_W  = 2,
  parameter int SKID_EN = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [CTRL_W-1:0]     ctrl_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  input  logic [NCH*DATA_W-1:0] data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [CTRL_W-1:0]     ctrl_o,
  output logic [ADDR_W-1:0]     rd_addr_o,
  output logic [NCH*DATA_W-1:0] data_o,
  output logic [15:0]           stall_cnt_o
);

  localparam int DW    = NCH * DATA_W;
  localparam int PAY_W = CTRL_W + ADDR_W + DW;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PAY_W-1:0] main_q, skid_q, in_pl;
  logic             accept, pop, clear;
  logic             load_main_in, load_main_skid, load_skid;
  logic [15:0]      stall_q;

  assign in_pl       = {ctrl_i, rd_addr_i, data_i};
  assign out_valid_o = start_i & (state_q != ST_EMPTY);
  assign accept      = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // With start_i low nothing moves; flush beats any handshake in the same cycle.
  always_comb begin
    state_d        = state_q;
    clear          = 1'b0;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (start_i) begin
      if (flush_i) begin
        state_d = ST_EMPTY;
        clear   = 1'b1;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (accept) begin
              state_d      = ST_FULL;
              load_main_in = 1'b1;
            end
          end
          ST_FULL: begin
            if (accept && pop) begin
              load_main_in = 1'b1;
            end else if (accept && (SKID_EN != 0)) begin
              state_d   = ST_SKID;
              load_skid = 1'b1;
            end else if (pop) begin
              state_d = ST_EMPTY;
            end
          end
          ST_SKID: begin
            if (pop) begin
              state_d        = ST_FULL;
              load_main_skid = 1'b1;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)              main_q <= '0;
    else if (clear)          main_q <= '0;
    else if (load_main_in)   main_q <= in_pl;
    else if (load_main_skid) main_q <= skid_q;
  end

  generate
    if (SKID_EN != 0) begin : g_skid
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)         skid_q <= '0;
        else if (clear)     skid_q <= '0;
        else if (load_skid) skid_q <= in_pl;
      end
      // Ready depends only on registered state, so out_ready_i never reaches in_ready_o.
      assign in_ready_o = rst_i & start_i & ~flush_i & (state_q != ST_SKID);
    end else begin : g_noskid
      assign skid_q     = '0;
      assign in_ready_o = rst_i & start_i & ~flush_i &
                          ((state_q == ST_EMPTY) | out_ready_i);
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      stall_q <= '0;
    else if (clear)
      stall_q <= '0;
    else if (out_valid_o && !out_ready_i && (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end

  assign data_o      = main_q[DW-1:0];
  assign rd_addr_o   = main_q[DW +: ADDR_W];
  assign ctrl_o      = main_q[PAY_W-1 -: CTRL_W] & {CTRL_W{out_valid_o}};
  assign stall_cnt_o = stall_q;

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 32, width of each data channel.
REQ-002 Parameter NCH, default 2, number of data channels carried (1..4).
REQ-003 Parameter ADDR_W, default 5, destination register address width.
REQ-004 Parameter CTRL_W, default 2, control-bit vector width (e.g. RegWrite, MemReg).
REQ-005 Parameter SKID_EN, default 1: 1 = two-entry skid buffer, 0 = single register with combinational ready pass-through.
REQ-006 clk_i  in  1  single clock; all state updates on rising edge.
REQ-007 rst_i  in  1  reset, asynchronous, active-low.
REQ-008 start_i  in  1  global enable; 0 freezes all state and blocks both handshakes.
REQ-009 flush_i  in  1  synchronous flush; discards stage contents.
REQ-010 in_valid_i  in  1  upstream payload valid.
REQ-011 in_ready_o  out  1  stage can accept payload this cycle.
REQ-012 ctrl_i  in  CTRL_W  control bits.
REQ-013 rd_addr_i  in  ADDR_W  destination address.
REQ-014 data_i  in  NCH*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
REQ-015 out_valid_o  out  1  downstream payload valid.
REQ-016 out_ready_i  in  1  downstream accepts payload.
REQ-017 ctrl_o, rd_addr_o, data_o  out  CTRL_W / ADDR_W / NCH*DATA_W  registered payload.
REQ-018 stall_cnt_o  out  16  saturating count of back-pressure cycles.

Function
REQ-019 Accept = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i; neither occurs when start_i=0.
REQ-020 States (SKID_EN=1): EMPTY, FULL (main reg holds payload), SKID (main and skid regs both hold payload).
REQ-021 Transitions: EMPTY+accept -> FULL; FULL+accept+pop -> FULL (main loads input); FULL+accept+!pop -> SKID (skid loads input); FULL+pop+!accept -> EMPTY; SKID+pop -> FULL (main loads skid); all other cases hold.
REQ-022 SKID_EN=1: in_ready_o = start_i & !flush_i & (state != SKID); no combinational path from out_ready_i to in_ready_o.
REQ-023 SKID_EN=0: only EMPTY/FULL exist; in_ready_o = start_i & !flush_i & (state==EMPTY | out_ready_i); SKID state unreachable, skid regs omitted.
REQ-024 out_valid_o = start_i & (state != EMPTY).
REQ-025 data_o and rd_addr_o always reflect the main register; first accepted payload appears at outputs one cycle after accept (latency 1).
REQ-026 ctrl_o = main ctrl bits ANDed with out_valid_o; bubbles never present asserted control bits.
REQ-027 Payload order strictly FIFO; no payload duplicated or dropped except by flush.
REQ-028 flush_i=1 with start_i=1: state -> EMPTY next edge, main and skid payload regs cleared to 0, any simultaneous accept is suppressed (in_ready_o=0); pop in that cycle still counts as completed downstream.
REQ-029 flush_i with start_i=0 is ignored.
REQ-030 stall_cnt_o increments by 1 each cycle with out_valid_o=1 and out_ready_i=0; saturates at 16'hFFFF; cleared by flush.
REQ-031 Channel count NCH changes only payload width; control logic identical for all NCH.

Reset
REQ-032 rst_i low asynchronously forces state EMPTY, all payload regs 0, stall_cnt_o 0; hence out_valid_o=0, ctrl_o=0, rd_addr_o=0, data_o=0.
REQ-033 in_ready_o during reset = 0 (output of gating by reset state handled as if start_i=0 while rst_i low).
REQ-034 Reset asserted mid-transfer discards all held payloads; first edge after rst_i high with start_i=1 may accept.

Verification
REQ-035 Pass-through: start_i=1, out_ready_i=1, inputs data_i={32'h1111_1111,32'hAAAA_0000}, rd_addr_i=7, ctrl_i=2'b11 valid one cycle -> next cycle out_valid_o=1 with identical payload, then out_valid_o=0, ctrl_o=0.
REQ-036 Skid fill: out_ready_i=0, push A then B -> state SKID, in_ready_o=0, out shows A; raise out_ready_i -> A, B delivered in order on consecutive cycles; stall_cnt_o=2 at release.
REQ-037 Flush: stage in SKID, flush_i=1 with in_valid_i=1 -> next cycle out_valid_o=0, data_o=0, stall_cnt_o=0, input not captured.
REQ-038 Freeze: state FULL, start_i=0 for 3 cycles with out_ready_i=1 -> out_valid_o=0, payload unchanged; start_i=1 -> same payload delivered once.
REQ-039 Async reset: assert rst_i low mid-clock while FULL -> outputs 0 immediately, before next edge.
REQ-040 SKID_EN=0 build: FULL, out_ready_i=1, in_valid_i=1 -> in_ready_o=1 same cycle, back-to-back throughput 1 per cycle; stall_cnt_o saturation checked at 16'hFFFF after 65536 stall cycles.
